// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths and packer state type for the audio sample FIFO
package audio_pkg;
   localparam int SAMPLE_W = 24;
   localparam int FRAME_W  = 2 * SAMPLE_W;

   typedef enum logic {PK_LEFT, PK_RIGHT} pk_state_t;
endpackage

// File: rtl/audio_sample_fifo_if.sv
// rtl/audio_sample_fifo_if.sv - sample-in / frame-out handshake bundle
interface audio_sample_fifo_if
   import audio_pkg::*;
#(
   parameter int W = SAMPLE_W
);
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] out_data;
   logic           out_valid;
   logic           out_ack;

   modport slave  (input in_data, in_valid, out_ack, output in_ready, out_data, out_valid);
   modport master (output in_data, in_valid, out_ack, input in_ready, out_data, out_valid);
endinterface

// File: rtl/audio_sample_fifo_fifo.sv
// rtl/audio_sample_fifo_fifo.sv - first-word-fall-through frame FIFO with flush
module sync_fifo_fwft #(
   parameter int WIDTH      = 48,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_rdata,
   output logic                  o_empty,
   output logic                  o_full,
   output logic [DEPTH_LOG2:0]   o_level
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  w_push;
   logic                  w_pop;

   assign o_empty = (r_level == '0);
   assign o_full  = (r_level == (DEPTH_LOG2+1)'(DEPTH));
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_level = r_level;
   // Head is read straight from the array; zero while empty so idle frames are silent
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
         r_level <= r_level + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst && !i_flush) r_mem[r_wptr] <= i_wdata;
   end
endmodule

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - packs L/R samples into stereo frames, buffers them for the I2S master
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int SAMPLE_W        = audio_pkg::SAMPLE_W,
   parameter int DEPTH_LOG2      = 4,
   parameter int ALMOST_EMPTY_TH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   audio_sample_fifo_if.slave       bus,
   input  logic                     flush,
   input  logic                     underrun_clear,
   output logic [DEPTH_LOG2:0]      level,
   output logic                     almost_empty,
   output logic [15:0]              underrun_count
);
   pk_state_t             r_state;
   pk_state_t             w_next;
   logic [SAMPLE_W-1:0]   r_left;
   logic [15:0]           r_ucnt;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_underrun;
   logic                  w_full;
   logic                  w_empty;
   logic [2*SAMPLE_W-1:0] w_rdata;

   always_ff @(posedge clk) begin
      if (rst || flush) r_state <= PK_LEFT;
      else              r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_push     = 1'b0;
      unique case (r_state)
         PK_LEFT:  w_in_ready = 1'b1;
         // No pass-through: a same-cycle pop does not free a slot for this push
         PK_RIGHT: w_in_ready = !w_full;
         default:  w_in_ready = 1'b0;
      endcase
      if (flush) w_in_ready = 1'b0;
      w_accept = bus.in_valid && w_in_ready;
      if (w_accept) begin
         w_next = (r_state == PK_LEFT) ? PK_RIGHT : PK_LEFT;
         w_push = (r_state == PK_RIGHT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush)                     r_left <= '0;
      else if (w_accept && r_state == PK_LEFT) r_left <= bus.in_data;
   end

   assign w_pop      = bus.out_ack && !w_empty && !flush;
   assign w_underrun = bus.out_ack && w_empty && !flush;

   always_ff @(posedge clk) begin
      if (rst || underrun_clear)              r_ucnt <= '0;
      else if (w_underrun && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
   end

   sync_fifo_fwft #(
      .WIDTH      (2*SAMPLE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push),
      .i_wdata ({r_left, bus.in_data}),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_level (level)
   );

   assign bus.in_ready   = w_in_ready;
   assign bus.out_data   = w_rdata;
   assign bus.out_valid  = !w_empty;
   assign almost_empty   = (level <= (DEPTH_LOG2+1)'(ALMOST_EMPTY_TH));
   assign underrun_count = r_ucnt;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - directed table and sequence bench for audio_sample_fifo
module tb_audio_sample_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        uclr = 1'b0;
   logic [4:0]  level;
   logic        almost_empty;
   logic [15:0] ucnt;
   int          checks = 0;
   int          failures = 0;

   audio_sample_fifo_if #(.W(24)) bus ();

   audio_sample_fifo #(.SAMPLE_W(24), .DEPTH_LOG2(4), .ALMOST_EMPTY_TH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .flush          (flush),
      .underrun_clear (uclr),
      .level          (level),
      .almost_empty   (almost_empty),
      .underrun_count (ucnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] d;
      logic        v;
      logic        fl;
      logic        uc;
      logic        ack;
      logic        e_ov;
      logic [47:0] e_od;
      logic [4:0]  e_lvl;
      logic        e_rdy;
      logic [15:0] e_uc;
      logic        e_ae;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] d);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [47:0] frame(input int k);
      return {24'h100000 + 24'(k), 24'h200000 + 24'(k)};
   endfunction

   initial begin
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.out_ack  = 1'b0;
      do_reset();

      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_data",  64'(bus.out_data),  64'd0);
      chk("reset_level",     64'(level),         64'd0);
      chk("reset_ucnt",      64'(ucnt),          64'd0);
      chk("reset_in_ready",  64'(bus.in_ready),  64'd1);
      chk("reset_almost_empty", 64'(almost_empty), 64'd1);

      //        d           v  fl uc ack  ov  od                 lvl rdy uc   ae
      vt.push_back('{24'h111111, 1, 0, 0, 0,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'h222222, 1, 0, 0, 0,  1, 48'h111111222222,  1, 1, 0, 1});
      vt.push_back('{24'h0,      0, 0, 0, 0,  1, 48'h111111222222,  1, 1, 0, 1});
      vt.push_back('{24'h0,      0, 0, 0, 1,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'h0,      0, 0, 0, 1,  0, 48'h0,             0, 1, 1, 1});
      vt.push_back('{24'h0,      0, 0, 0, 1,  0, 48'h0,             0, 1, 2, 1});
      vt.push_back('{24'h0,      0, 0, 0, 1,  0, 48'h0,             0, 1, 3, 1});
      vt.push_back('{24'h0,      0, 0, 1, 0,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'h0,      0, 0, 1, 1,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'hAAAAAA, 1, 0, 0, 0,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'hBBBBBB, 1, 1, 0, 0,  0, 48'h0,             0, 0, 0, 1});
      vt.push_back('{24'hCCCCCC, 1, 0, 0, 0,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'hDDDDDD, 1, 0, 0, 0,  1, 48'hCCCCCCDDDDDD,  1, 1, 0, 1});
      vt.push_back('{24'h0,      0, 0, 0, 1,  0, 48'h0,             0, 1, 0, 1});
      vt.push_back('{24'h010101, 1, 0, 0, 1,  0, 48'h0,             0, 1, 1, 1});
      vt.push_back('{24'h020202, 1, 0, 0, 1,  1, 48'h010101020202,  1, 1, 2, 1});
      vt.push_back('{24'h0,      0, 1, 0, 1,  0, 48'h0,             0, 0, 2, 1});
      vt.push_back('{24'h0,      0, 0, 0, 0,  0, 48'h0,             0, 1, 2, 1});

      foreach (vt[i]) begin
         bus.in_data  = vt[i].d;
         bus.in_valid = vt[i].v;
         flush        = vt[i].fl;
         uclr         = vt[i].uc;
         bus.out_ack  = vt[i].ack;
         tick();
         chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].e_ov));
         chk($sformatf("vec%0d_out_data", i),  64'(bus.out_data),  64'(vt[i].e_od));
         chk($sformatf("vec%0d_level", i),     64'(level),         64'(vt[i].e_lvl));
         chk($sformatf("vec%0d_in_ready", i),  64'(bus.in_ready),  64'(vt[i].e_rdy));
         chk($sformatf("vec%0d_ucnt", i),      64'(ucnt),          64'(vt[i].e_uc));
         chk($sformatf("vec%0d_almost_empty", i), 64'(almost_empty), 64'(vt[i].e_ae));
      end
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      uclr         = 1'b0;
      bus.out_ack  = 1'b0;

      // Reset in the middle of a frame discards the latched left sample
      send(24'hAAAAAA);
      do_reset();
      chk("midreset_level", 64'(level), 64'd0);
      chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
      send(24'h333333);
      send(24'h444444);
      chk("midreset_pairing", 64'(bus.out_data), 64'h333333444444);

      // Fill to 16 frames, block the 17th right sample, release with one ack
      do_reset();
      for (int k = 0; k < 16; k++) begin
         send(frame(k)[47:24]);
         send(frame(k)[23:0]);
      end
      chk("full_level", 64'(level), 64'd16);
      chk("full_almost_empty", 64'(almost_empty), 64'd0);
      chk("full_head", 64'(bus.out_data), 64'(frame(0)));
      send(frame(16)[47:24]);
      chk("full_in_ready_right", 64'(bus.in_ready), 64'd0);
      bus.in_data  = frame(16)[23:0];
      bus.in_valid = 1'b1;
      tick();
      chk("full_held_level", 64'(level), 64'd16);
      chk("full_held_in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      chk("ack_level", 64'(level), 64'd15);
      chk("ack_in_ready", 64'(bus.in_ready), 64'd1);
      chk("ack_head", 64'(bus.out_data), 64'(frame(1)));
      tick();
      bus.in_valid = 1'b0;
      chk("refill_level", 64'(level), 64'd16);
      chk("refill_in_ready", 64'(bus.in_ready), 64'd1);

      // Drain to 5 with a held ack, then push and pop together
      bus.out_ack = 1'b1;
      repeat (11) tick();
      bus.out_ack = 1'b0;
      chk("drain_level", 64'(level), 64'd5);
      chk("drain_head", 64'(bus.out_data), 64'(frame(12)));
      send(24'h555555);
      bus.in_data  = 24'h666666;
      bus.in_valid = 1'b1;
      bus.out_ack  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.out_ack  = 1'b0;
      chk("pushpop_level", 64'(level), 64'd5);
      chk("pushpop_head", 64'(bus.out_data), 64'(frame(13)));
      bus.out_ack = 1'b1;
      repeat (4) tick();
      bus.out_ack = 1'b0;
      chk("order_tail_head", 64'(bus.out_data), 64'h555555666666);
      chk("order_tail_level", 64'(level), 64'd1);

      // Underrun counter saturation
      do_reset();
      bus.out_ack = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", 64'(ucnt), 64'hFFFE);
      repeat (3) tick();
      bus.out_ack = 1'b0;
      chk("sat_ffff", 64'(ucnt), 64'hFFFF);
      chk("sat_level", 64'(level), 64'd0);
      uclr = 1'b1;
      tick();
      uclr = 1'b0;
      chk("sat_clear", 64'(ucnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
